// File: rtl/bist_pkg.sv
// bist_pkg: shared types and constants for the BIST wrapper and its b01 CUT
package bist_pkg;
    localparam int W = 8;
    localparam logic [W-1:0] SEED = 8'h01;
    // taps x^8+x^6+x^5+x^4+1 -> feedback from bits 7,5,4,3
    localparam logic [W-1:0] TAP_MASK = 8'hB8;

    typedef enum logic [1:0] {C_IDLE, C_RUN, C_FLUSH, C_DONE} ctrl_t;
    typedef enum logic [2:0] {S_A, S_B, S_C, S_E, S_F, S_G, S_WF0, S_WF1} cut_t;

    function automatic logic [W-1:0] shift_fb(input logic [W-1:0] v);
        return {v[W-2:0], ^(v & TAP_MASK)};
    endfunction
endpackage

// File: rtl/bist_if.sv
// bist_if: BIST request/result handshake between a test master and the wrapper
interface bist_if;
    logic bist_start;
    logic bist_end;
    logic pass_nfail;
    modport master (output bist_start, input bist_end, input pass_nfail);
    modport slave (input bist_start, output bist_end, output pass_nfail);
endinterface

// File: rtl/b01.sv
// b01: ITC'99 b01 serial-flow comparator FSM with registered outputs
module b01
    import bist_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic en,
    input  logic line1,
    input  logic line2,
    output logic outp,
    output logic overflw
);
    cut_t state_q, state_d;
    logic outp_q, outp_d, overflw_q, overflw_d;
    logic x, both, any;

    assign x    = line1 ^ line2;
    assign both = line1 & line2;
    assign any  = line1 | line2;

    // next state and registered outputs; clear wins over enable
    always_comb begin
        state_d   = state_q;
        outp_d    = outp_q;
        overflw_d = overflw_q;
        if (clr) begin
            state_d   = S_A;
            outp_d    = 1'b0;
            overflw_d = 1'b0;
        end else if (en) begin
            overflw_d = (state_q == S_E);
            case (state_q)
                S_A, S_E: begin state_d = both ? S_F : S_B;     outp_d = x;  end
                S_B:      begin state_d = both ? S_G : S_C;     outp_d = x;  end
                S_F:      begin state_d = any ? S_G : S_C;      outp_d = ~x; end
                S_C:      begin state_d = both ? S_WF1 : S_WF0; outp_d = x;  end
                S_G:      begin state_d = any ? S_WF1 : S_WF0;  outp_d = ~x; end
                S_WF0:    begin state_d = both ? S_E : S_A;     outp_d = x;  end
                default:  begin state_d = any ? S_E : S_A;      outp_d = ~x; end
            endcase
        end
    end

    // state and output registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= S_A;
            outp_q    <= 1'b0;
            overflw_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            outp_q    <= outp_d;
            overflw_q <= overflw_d;
        end
    end

    assign outp    = outp_q;
    assign overflw = overflw_q;
endmodule

// File: rtl/bist_top_level.sv
// bist_top_level: LFSR-driven self test of b01 with MISR signature compare
module bist_top_level
    import bist_pkg::*;
#(
    parameter int          N_PATTERNS = 255,
    parameter logic [W-1:0] GOLDEN_SIG = 8'h00
) (
    input  logic   clock,
    input  logic   reset,
    bist_if.slave  bus
);
    localparam logic [15:0] LAST = 16'(N_PATTERNS - 1);

    ctrl_t ctrl_q, ctrl_d;
    logic [W-1:0] lfsr_q, lfsr_d, misr_q, misr_d, misr_next;
    logic [15:0] cnt_q, cnt_d;
    logic end_q, end_d, pass_q, pass_d;
    logic clr, cut_en, outp, overflw;

    b01 u_cut (
        .clock   (clock),
        .reset   (reset),
        .clr     (clr),
        .en      (cut_en),
        .line1   (lfsr_q[0]),
        .line2   (lfsr_q[1]),
        .outp    (outp),
        .overflw (overflw)
    );

    assign misr_next = shift_fb(misr_q) ^ {6'b0, overflw, outp};

    // controller: start restarts from IDLE/DONE, RUN counts patterns, FLUSH takes last response
    always_comb begin
        ctrl_d = ctrl_q;
        lfsr_d = lfsr_q;
        misr_d = misr_q;
        cnt_d  = cnt_q;
        end_d  = end_q;
        pass_d = pass_q;
        clr    = 1'b0;
        cut_en = 1'b0;
        case (ctrl_q)
            C_IDLE, C_DONE: if (bus.bist_start) begin
                ctrl_d = C_RUN;
                lfsr_d = SEED;
                misr_d = '0;
                cnt_d  = '0;
                clr    = 1'b1;
                end_d  = 1'b0;
                pass_d = 1'b0;
            end
            C_RUN: begin
                lfsr_d = shift_fb(lfsr_q);
                misr_d = misr_next;
                cut_en = 1'b1;
                cnt_d  = cnt_q + 16'd1;
                ctrl_d = (cnt_q == LAST) ? C_FLUSH : C_RUN;
            end
            C_FLUSH: begin
                misr_d = misr_next;
                ctrl_d = C_DONE;
                end_d  = 1'b1;
                pass_d = (misr_next == GOLDEN_SIG);
            end
            default: ctrl_d = C_IDLE;
        endcase
    end

    // controller, pattern generator, signature and result registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ctrl_q <= C_IDLE;
            lfsr_q <= SEED;
            misr_q <= '0;
            cnt_q  <= '0;
            end_q  <= 1'b0;
            pass_q <= 1'b0;
        end else begin
            ctrl_q <= ctrl_d;
            lfsr_q <= lfsr_d;
            misr_q <= misr_d;
            cnt_q  <= cnt_d;
            end_q  <= end_d;
            pass_q <= pass_d;
        end
    end

    assign bus.bist_end   = end_q;
    assign bus.pass_nfail = pass_q;
endmodule

// File: tb/tb_bist_top_level.sv
// tb_bist_top_level: random-start bench with a signature model and b01 directed check
module tb_bist_top_level;
    import bist_pkg::*;

    localparam int N = 255;

    // plain x^8+x^6+x^5+x^4+1 shift
    function automatic logic [7:0] step8(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    // b01 behaviour: state codes a=0 b=1 c=2 e=3 f=4 g=5 wf0=6 wf1=7; returns {next, outp, overflw}
    function automatic logic [4:0] cut_step(input logic [2:0] st, input logic l1, input logic l2);
        logic hit, inv;
        logic [2:0] t, f;
        case (st)
            3'd0, 3'd3: begin hit = l1 & l2; t = 3'd4; f = 3'd1; inv = 1'b0; end
            3'd1:       begin hit = l1 & l2; t = 3'd5; f = 3'd2; inv = 1'b0; end
            3'd4:       begin hit = l1 | l2; t = 3'd5; f = 3'd2; inv = 1'b1; end
            3'd2:       begin hit = l1 & l2; t = 3'd7; f = 3'd6; inv = 1'b0; end
            3'd5:       begin hit = l1 | l2; t = 3'd7; f = 3'd6; inv = 1'b1; end
            3'd6:       begin hit = l1 & l2; t = 3'd3; f = 3'd0; inv = 1'b0; end
            default:    begin hit = l1 | l2; t = 3'd3; f = 3'd0; inv = 1'b1; end
        endcase
        return {hit ? t : f, (l1 ^ l2) ^ inv, st == 3'd3};
    endfunction

    // signature after n patterns plus the final flush sample
    function automatic logic [7:0] sig_model(input int n);
        logic [7:0] q, m;
        logic [4:0] r;
        logic [2:0] st;
        logic o, v;
        q = 8'h01; m = 8'h00; st = 3'd0; o = 1'b0; v = 1'b0;
        for (int i = 0; i < n; i++) begin
            m = step8(m) ^ {6'b0, v, o};
            r = cut_step(st, q[0], q[1]);
            st = r[4:2]; o = r[1]; v = r[0];
            q = step8(q);
        end
        return step8(m) ^ {6'b0, v, o};
    endfunction

    localparam logic [7:0] SIG    = sig_model(N);
    localparam logic [7:0] GOLD_P = SIG;
    localparam logic [7:0] GOLD_F = SIG ^ 8'h01;

    logic clock = 1'b0;
    logic reset, start;
    logic c_clr, c_en, c_l1, c_l2, c_o, c_v;
    int checks = 0, failures = 0;
    int m_left;
    logic m_end, m_pass_p, m_pass_f;

    always #5 clock = ~clock;

    bist_if if_p ();
    bist_if if_f ();
    assign if_p.bist_start = start;
    assign if_f.bist_start = start;

    bist_top_level #(.N_PATTERNS(N), .GOLDEN_SIG(GOLD_P)) u_p (.clock(clock), .reset(reset), .bus(if_p));
    bist_top_level #(.N_PATTERNS(N), .GOLDEN_SIG(GOLD_F)) u_f (.clock(clock), .reset(reset), .bus(if_f));

    b01 u_cut (
        .clock(clock), .reset(reset), .clr(c_clr), .en(c_en),
        .line1(c_l1), .line2(c_l2), .outp(c_o), .overflw(c_v)
    );

    // run-level model: a start from idle/done takes N+1 edges to produce a held result
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_left <= 0; m_end <= 1'b0; m_pass_p <= 1'b0; m_pass_f <= 1'b0;
        end else if (m_left == 0 && start) begin
            m_left <= N + 1; m_end <= 1'b0; m_pass_p <= 1'b0; m_pass_f <= 1'b0;
        end else if (m_left != 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_end <= 1'b1;
                m_pass_p <= (SIG == GOLD_P);
                m_pass_f <= (SIG == GOLD_F);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic pulse_start();
        @(negedge clock); start = 1'b1;
        @(negedge clock); start = 1'b0;
    endtask

    task automatic wait_result(input string name);
        int w = 0;
        while (!if_p.bist_end && w < 400) begin @(negedge clock); w++; end
        chk(name, if_p.bist_end, 1);
    endtask

    logic [7:0] lfsr_exp [1:5] = '{8'h02, 8'h04, 8'h08, 8'h11, 8'h23};
    cut_t st_exp [4] = '{S_F, S_C, S_WF0, S_A};
    logic [1:0] lines [4] = '{2'b11, 2'b00, 2'b10, 2'b00};
    logic [3:0] outp_exp = 4'b0110;
    logic [4:0] mdl_exp [4] = '{5'b10000, 5'b01010, 5'b11010, 5'b00000};

    initial begin
        logic [2:0] mst;
        logic [4:0] r;
        int lat;
        reset = 1'b0; start = 1'b0;
        c_clr = 1'b0; c_en = 1'b0; c_l1 = 1'b0; c_l2 = 1'b0;
        fork
            forever begin
                @(negedge clock);
                chk("end_p", if_p.bist_end, m_end);
                chk("pass_p", if_p.pass_nfail, m_pass_p);
                chk("end_f", if_f.bist_end, m_end);
                chk("pass_f", if_f.pass_nfail, m_pass_f);
            end
        join_none
        #100;
        chk("reset_end", if_p.bist_end, 0);
        chk("reset_pass", if_p.pass_nfail, 0);
        @(negedge clock); reset = 1'b1;

        // pin the model with hand-derived values
        chk("model_sig1", sig_model(1), 8'h01);
        chk("model_sig2", sig_model(2), 8'h03);
        mst = 3'd0;
        for (int i = 0; i < 4; i++) begin
            r = cut_step(mst, lines[i][1], lines[i][0]);
            chk("model_cut", r, mdl_exp[i]);
            mst = r[4:2];
        end

        // b01 on its own
        for (int i = 0; i < 4; i++) begin
            @(negedge clock); c_en = 1'b1; c_l1 = lines[i][1]; c_l2 = lines[i][0];
            @(posedge clock); #1;
            chk("cut_state", u_cut.state_q, st_exp[i]);
            chk("cut_outp", c_o, outp_exp[3 - i]);
            chk("cut_overflw", c_v, 0);
        end
        @(negedge clock); c_en = 1'b0;
        repeat (20) @(negedge clock);

        // latency, pattern sequence, and a start ignored mid-run
        start = 1'b1;
        @(posedge clock); #1; start = 1'b0;
        lat = 0;
        for (int i = 1; i <= 400; i++) begin
            @(posedge clock); #1;
            if (i <= 5) chk("lfsr_seq", u_p.lfsr_q, lfsr_exp[i]);
            start = (i == 50);
            if (if_p.bist_end) begin lat = i; break; end
        end
        start = 1'b0;
        chk("latency", lat, N + 1);
        chk("pass_result", if_p.pass_nfail, 1);
        chk("fail_result", if_f.pass_nfail, 0);
        chk("fail_end", if_f.bist_end, 1);
        repeat (10) @(negedge clock);

        // random restarts with stray starts during the run
        repeat (6) begin
            repeat ($urandom_range(0, 20)) @(negedge clock);
            @(negedge clock); start = 1'b1;
            repeat ($urandom_range(1, 3)) @(negedge clock);
            start = 1'b0;
            repeat ($urandom_range(10, 200)) @(negedge clock);
            start = 1'b1;
            @(negedge clock); start = 1'b0;
            wait_result("run_done");
        end

        // level start keeps restarting
        @(negedge clock); start = 1'b1;
        repeat (600) @(negedge clock);
        start = 1'b0;
        wait_result("level_done");

        // asynchronous abort at RUN cycle 100
        pulse_start();
        repeat (99) @(posedge clock);
        #3 reset = 1'b0;
        #1;
        chk("abort_end", if_p.bist_end, 0);
        chk("abort_pass", if_p.pass_nfail, 0);
        @(negedge clock); reset = 1'b1;
        repeat (300) @(negedge clock);

        // asynchronous clear of a held result
        pulse_start();
        wait_result("pre_clear");
        @(posedge clock); #3 reset = 1'b0;
        #1;
        chk("clear_end", if_p.bist_end, 0);
        chk("clear_pass", if_p.pass_nfail, 0);
        @(negedge clock); reset = 1'b1;
        repeat (10) @(negedge clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
